// File: rtl/accelerator_dnc_pkg.sv
// Shared definitions for the DNC read-head interface parser.
// Contents:
//   parse_state_e - parser FSM states (IDLE, KEY, STRENGTH, GATE, MODE)
//   PI_WORDS      - read-mode words per head
//   ONE, ZERO     - Q32.32 fixed-point constants for the default word format
//   total_words() - number of interface words consumed for a given R'/W'
package accelerator_dnc_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KEY      = 3'd1,
        STRENGTH = 3'd2,
        GATE     = 3'd3,
        MODE     = 3'd4
    } parse_state_e;

    localparam int unsigned PI_WORDS = 32'd3;

    localparam logic signed [63:0] ONE  = 64'sh0000_0001_0000_0000;
    localparam logic signed [63:0] ZERO = 64'sd0;

    // Each head carries its key, one strength, one free gate and the mode words.
    function automatic logic [63:0] total_words(input logic [63:0] size_r,
                                                input logic [63:0] size_w);
        return size_r * (size_w + 64'(PI_WORDS) + 64'd2);
    endfunction

endpackage

// File: rtl/accelerator_fixed_clamp.sv
// Signed fixed-point range limiter (purely combinational).
// Ports:
//   value   in  DATA_SIZE  signed input word
//   clamped out DATA_SIZE  value limited to [LO, HI], or to [LO, +inf) when HAS_HI = 0
module accelerator_fixed_clamp #(
    parameter int                          DATA_SIZE = 64,
    parameter logic signed [DATA_SIZE-1:0] LO        = '0,
    parameter logic signed [DATA_SIZE-1:0] HI        = '0,
    parameter bit                          HAS_HI    = 1'b1
) (
    input  logic signed [DATA_SIZE-1:0] value,
    output logic signed [DATA_SIZE-1:0] clamped
);

    // Lower bound first, then the optional upper bound.
    always_comb begin
        if (value < LO) begin
            clamped = LO;
        end else if (HAS_HI && (value > HI)) begin
            clamped = HI;
        end else begin
            clamped = value;
        end
    end

endmodule

// File: rtl/accelerator_read_heads_parser.sv
// Demultiplexes the read-head section of the controller interface vector.
// Per head the serial stream holds W' key words, one strength, one free gate
// and PI_WORDS mode words; heads arrive in order 0..R'-1.
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   START                            begin a parse (sampled in IDLE only)
//   READY / ERROR                    completion pulse / size-rejection pulse
//   SIZE_R_IN, SIZE_W_IN             heads in use (1..R), key length (1..W)
//   IFACE_IN_ENABLE, IFACE_IN        input word strobe and data
//   HEAD_OUT                         head index of the word being presented
//   K_OUT_I_ENABLE/K_ENABLE, K_OUT   key stream (I marks the first word)
//   BETA_OUT_ENABLE, BETA_OUT        strength, clamped to >= ONE
//   F_OUT_ENABLE, F_OUT              free gate, clamped to [0, ONE]
//   PI_OUT_I_ENABLE/P_ENABLE, PI_OUT mode stream (I marks the first word)
// All outputs are registered: a word accepted at edge n appears after edge n.
module accelerator_read_heads_parser
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FRACT_SIZE   = 32,
    parameter int R            = 4,
    parameter int W            = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    ERROR,
    input  logic [CONTROL_SIZE-1:0] SIZE_R_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_W_IN,
    input  logic                    IFACE_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    IFACE_IN,
    output logic [CONTROL_SIZE-1:0] HEAD_OUT,
    output logic                    K_OUT_I_ENABLE,
    output logic                    K_OUT_K_ENABLE,
    output logic [DATA_SIZE-1:0]    K_OUT,
    output logic                    BETA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    BETA_OUT,
    output logic                    F_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    F_OUT,
    output logic                    PI_OUT_I_ENABLE,
    output logic                    PI_OUT_P_ENABLE,
    output logic [DATA_SIZE-1:0]    PI_OUT
);

    localparam logic signed [DATA_SIZE-1:0] ONE_L  = {{(DATA_SIZE-1){1'b0}}, 1'b1} << FRACT_SIZE;
    localparam logic signed [DATA_SIZE-1:0] ZERO_L = DATA_SIZE'(ZERO);
    localparam logic [CONTROL_SIZE-1:0] CTRL_ZERO  = {CONTROL_SIZE{1'b0}};
    localparam logic [CONTROL_SIZE-1:0] CTRL_ONE   = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};
    localparam logic [CONTROL_SIZE-1:0] PI_LAST    = CONTROL_SIZE'(PI_WORDS - 32'd1);

    parse_state_e state_r, state_s;
    logic [CONTROL_SIZE-1:0] head_r, head_s, word_r, word_s;
    logic [CONTROL_SIZE-1:0] size_r_r, size_r_s, size_w_r, size_w_s;

    logic sizes_ok_s, last_key_s, last_pi_s, last_head_s;
    logic signed [DATA_SIZE-1:0] iface_s, beta_clamped_s, f_clamped_s;

    logic ready_r, ready_s, error_r, error_s;
    logic [CONTROL_SIZE-1:0] head_out_r, head_out_s;
    logic k_i_r, k_i_s, k_k_r, k_k_s, beta_en_r, beta_en_s, f_en_r, f_en_s;
    logic pi_i_r, pi_i_s, pi_p_r, pi_p_s;
    logic [DATA_SIZE-1:0] k_r, k_s, beta_r, beta_s, f_r, f_s, pi_r, pi_s;

    assign iface_s     = IFACE_IN;
    assign sizes_ok_s  = (SIZE_R_IN != CTRL_ZERO) && (SIZE_R_IN <= CONTROL_SIZE'(R)) &&
                         (SIZE_W_IN != CTRL_ZERO) && (SIZE_W_IN <= CONTROL_SIZE'(W));
    // Group boundaries compare against the sizes latched at START only.
    assign last_key_s  = (word_r == (size_w_r - CTRL_ONE));
    assign last_pi_s   = (word_r == PI_LAST);
    assign last_head_s = (head_r == (size_r_r - CTRL_ONE));

    accelerator_fixed_clamp #(
        .DATA_SIZE(DATA_SIZE), .LO(ONE_L), .HI(ONE_L), .HAS_HI(1'b0)
    ) u_beta_clamp (
        .value(iface_s), .clamped(beta_clamped_s)
    );

    accelerator_fixed_clamp #(
        .DATA_SIZE(DATA_SIZE), .LO(ZERO_L), .HI(ONE_L), .HAS_HI(1'b1)
    ) u_f_clamp (
        .value(iface_s), .clamped(f_clamped_s)
    );

    // FSM state, counters and latched sizes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            head_r   <= CTRL_ZERO;
            word_r   <= CTRL_ZERO;
            size_r_r <= CTRL_ZERO;
            size_w_r <= CTRL_ZERO;
        end else begin
            state_r  <= state_s;
            head_r   <= head_s;
            word_r   <= word_s;
            size_r_r <= size_r_s;
            size_w_r <= size_w_s;
        end
    end

    // Next-state logic; every non-idle transition waits for an accepted word.
    always_comb begin
        state_s  = state_r;
        head_s   = head_r;
        word_s   = word_r;
        size_r_s = size_r_r;
        size_w_s = size_w_r;
        case (state_r)
            IDLE: begin
                if (START && sizes_ok_s) begin
                    size_r_s = SIZE_R_IN;
                    size_w_s = SIZE_W_IN;
                    head_s   = CTRL_ZERO;
                    word_s   = CTRL_ZERO;
                    state_s  = KEY;
                end else begin
                    state_s = IDLE;
                end
            end
            KEY: begin
                if (IFACE_IN_ENABLE && last_key_s) begin
                    word_s  = CTRL_ZERO;
                    state_s = STRENGTH;
                end else if (IFACE_IN_ENABLE) begin
                    word_s = word_r + CTRL_ONE;
                end else begin
                    word_s = word_r;
                end
            end
            STRENGTH: begin
                if (IFACE_IN_ENABLE) begin
                    state_s = GATE;
                end else begin
                    state_s = STRENGTH;
                end
            end
            GATE: begin
                if (IFACE_IN_ENABLE) begin
                    state_s = MODE;
                end else begin
                    state_s = GATE;
                end
            end
            MODE: begin
                if (IFACE_IN_ENABLE && last_pi_s) begin
                    word_s = CTRL_ZERO;
                    if (last_head_s) begin
                        state_s = IDLE;
                    end else begin
                        head_s  = head_r + CTRL_ONE;
                        state_s = KEY;
                    end
                end else if (IFACE_IN_ENABLE) begin
                    word_s = word_r + CTRL_ONE;
                end else begin
                    word_s = word_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode: enables default low, data holds its last value.
    always_comb begin
        ready_s    = 1'b0;
        error_s    = 1'b0;
        head_out_s = head_out_r;
        k_i_s      = 1'b0;
        k_k_s      = 1'b0;
        k_s        = k_r;
        beta_en_s  = 1'b0;
        beta_s     = beta_r;
        f_en_s     = 1'b0;
        f_s        = f_r;
        pi_i_s     = 1'b0;
        pi_p_s     = 1'b0;
        pi_s       = pi_r;
        case (state_r)
            IDLE: begin
                if (START && !sizes_ok_s) begin
                    ready_s = 1'b1;
                    error_s = 1'b1;
                end else begin
                    ready_s = 1'b0;
                end
            end
            KEY: begin
                if (IFACE_IN_ENABLE) begin
                    head_out_s = head_r;
                    k_k_s      = 1'b1;
                    k_i_s      = (word_r == CTRL_ZERO);
                    k_s        = IFACE_IN;
                end else begin
                    k_k_s = 1'b0;
                end
            end
            STRENGTH: begin
                if (IFACE_IN_ENABLE) begin
                    head_out_s = head_r;
                    beta_en_s  = 1'b1;
                    beta_s     = beta_clamped_s;
                end else begin
                    beta_en_s = 1'b0;
                end
            end
            GATE: begin
                if (IFACE_IN_ENABLE) begin
                    head_out_s = head_r;
                    f_en_s     = 1'b1;
                    f_s        = f_clamped_s;
                end else begin
                    f_en_s = 1'b0;
                end
            end
            MODE: begin
                if (IFACE_IN_ENABLE) begin
                    head_out_s = head_r;
                    pi_p_s     = 1'b1;
                    pi_i_s     = (word_r == CTRL_ZERO);
                    pi_s       = IFACE_IN;
                    ready_s    = last_pi_s && last_head_s;
                end else begin
                    pi_p_s = 1'b0;
                end
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_r    <= 1'b0;
            error_r    <= 1'b0;
            head_out_r <= CTRL_ZERO;
            k_i_r      <= 1'b0;
            k_k_r      <= 1'b0;
            k_r        <= {DATA_SIZE{1'b0}};
            beta_en_r  <= 1'b0;
            beta_r     <= {DATA_SIZE{1'b0}};
            f_en_r     <= 1'b0;
            f_r        <= {DATA_SIZE{1'b0}};
            pi_i_r     <= 1'b0;
            pi_p_r     <= 1'b0;
            pi_r       <= {DATA_SIZE{1'b0}};
        end else begin
            ready_r    <= ready_s;
            error_r    <= error_s;
            head_out_r <= head_out_s;
            k_i_r      <= k_i_s;
            k_k_r      <= k_k_s;
            k_r        <= k_s;
            beta_en_r  <= beta_en_s;
            beta_r     <= beta_s;
            f_en_r     <= f_en_s;
            f_r        <= f_s;
            pi_i_r     <= pi_i_s;
            pi_p_r     <= pi_p_s;
            pi_r       <= pi_s;
        end
    end

    assign READY           = ready_r;
    assign ERROR           = error_r;
    assign HEAD_OUT        = head_out_r;
    assign K_OUT_I_ENABLE  = k_i_r;
    assign K_OUT_K_ENABLE  = k_k_r;
    assign K_OUT           = k_r;
    assign BETA_OUT_ENABLE = beta_en_r;
    assign BETA_OUT        = beta_r;
    assign F_OUT_ENABLE    = f_en_r;
    assign F_OUT           = f_r;
    assign PI_OUT_I_ENABLE = pi_i_r;
    assign PI_OUT_P_ENABLE = pi_p_r;
    assign PI_OUT          = pi_r;

endmodule

// File: tb/tb_accelerator_read_heads_parser.sv
// Scoreboard bench for accelerator_read_heads_parser (R=2, W=3, Q32.32).
module tb_accelerator_read_heads_parser;
    import accelerator_dnc_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        READY, ERROR;
    logic [63:0] SIZE_R_IN = 64'd0;
    logic [63:0] SIZE_W_IN = 64'd0;
    logic        IFACE_IN_ENABLE = 1'b0;
    logic [63:0] IFACE_IN = 64'd0;
    logic [63:0] HEAD_OUT;
    logic        K_OUT_I_ENABLE, K_OUT_K_ENABLE;
    logic [63:0] K_OUT;
    logic        BETA_OUT_ENABLE;
    logic [63:0] BETA_OUT;
    logic        F_OUT_ENABLE;
    logic [63:0] F_OUT;
    logic        PI_OUT_I_ENABLE, PI_OUT_P_ENABLE;
    logic [63:0] PI_OUT;

    accelerator_read_heads_parser #(
        .DATA_SIZE(64), .CONTROL_SIZE(64), .FRACT_SIZE(32), .R(2), .W(3)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .ERROR(ERROR),
        .SIZE_R_IN(SIZE_R_IN), .SIZE_W_IN(SIZE_W_IN),
        .IFACE_IN_ENABLE(IFACE_IN_ENABLE), .IFACE_IN(IFACE_IN),
        .HEAD_OUT(HEAD_OUT),
        .K_OUT_I_ENABLE(K_OUT_I_ENABLE), .K_OUT_K_ENABLE(K_OUT_K_ENABLE), .K_OUT(K_OUT),
        .BETA_OUT_ENABLE(BETA_OUT_ENABLE), .BETA_OUT(BETA_OUT),
        .F_OUT_ENABLE(F_OUT_ENABLE), .F_OUT(F_OUT),
        .PI_OUT_I_ENABLE(PI_OUT_I_ENABLE), .PI_OUT_P_ENABLE(PI_OUT_P_ENABLE), .PI_OUT(PI_OUT)
    );

    always #5 CLK = ~CLK;

    // flags: [7] K_I [6] K_K [5] BETA [4] F [3] PI_I [2] PI_P [1] READY [0] ERROR
    typedef struct {
        logic [7:0]  flags;
        logic [63:0] head;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] stim_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected output for stream word idx of a parse with sizes sr/sw.
    task automatic push_word(input int idx, input logic [63:0] v, input int sr, input int sw,
                             input int at_cyc);
        exp_t e;
        int   grp, p;
        grp    = sw + 5;
        p      = idx % grp;
        e.head = 64'(idx / grp);
        e.cyc  = at_cyc;
        e.flags = 8'd0;
        e.data = v;
        if (p < sw) begin
            e.flags[6] = 1'b1;
            e.flags[7] = (p == 0);
        end else if (p == sw) begin
            e.flags[5] = 1'b1;
            e.data = ($signed(v) < $signed(ONE)) ? ONE : v;
        end else if (p == sw + 1) begin
            e.flags[4] = 1'b1;
            e.data = ($signed(v) < 64'sd0) ? 64'd0 : (($signed(v) > $signed(ONE)) ? ONE : v);
        end else begin
            e.flags[2] = 1'b1;
            e.flags[3] = (p == sw + 2);
            e.flags[1] = (64'(idx) == total_words(64'(sr), 64'(sw)) - 64'd1);
        end
        exp_q.push_back(e);
    endtask

    // Drives START then every word of stim_q; gaps inserts an idle cycle after each word.
    task automatic send_stream(input int sr, input int sw, input bit gaps, input int start_at);
        tick();
        START = 1'b1;
        SIZE_R_IN = 64'(sr);
        SIZE_W_IN = 64'(sw);
        IFACE_IN_ENABLE = 1'b0;
        tick();
        START = 1'b0;
        SIZE_R_IN = 64'd0;   // latched sizes must be used from here on
        SIZE_W_IN = 64'd7;
        for (int i = 0; i < stim_q.size(); i++) begin
            IFACE_IN_ENABLE = 1'b1;
            IFACE_IN = stim_q[i];
            START = (i == start_at);
            SIZE_R_IN = 64'd2;
            SIZE_W_IN = 64'd3;
            push_word(i, stim_q[i], sr, sw, cyc + 1);
            tick();
            START = 1'b0;
            if (gaps) begin
                IFACE_IN_ENABLE = 1'b0;
                IFACE_IN = 64'hDEAD;
                tick();
            end
        end
        IFACE_IN_ENABLE = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic bad_start(input int sr, input int sw);
        exp_t e;
        tick();
        START = 1'b1;
        SIZE_R_IN = 64'(sr);
        SIZE_W_IN = 64'(sw);
        e.flags = 8'b0000_0011;
        e.head = 64'd0;
        e.data = 64'd0;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
        tick();
        START = 1'b0;
        IFACE_IN_ENABLE = 1'b1;  // ignored in IDLE: no outputs may follow
        IFACE_IN = 64'd77;
        tick();
        tick();
        IFACE_IN_ENABLE = 1'b0;
        drain();
    endtask

    logic [7:0] obs_flags;
    exp_t       e_mon;

    // Scoreboard: every output event is matched against the next expectation.
    always @(negedge CLK) begin
        obs_flags = {K_OUT_I_ENABLE, K_OUT_K_ENABLE, BETA_OUT_ENABLE, F_OUT_ENABLE,
                     PI_OUT_I_ENABLE, PI_OUT_P_ENABLE, READY, ERROR};
        if (obs_flags != 8'd0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected", {56'd0, obs_flags}, 64'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("flags", {56'd0, obs_flags}, {56'd0, e_mon.flags});
                chk("cycle", 64'(cyc), 64'(e_mon.cyc));
                if (e_mon.flags[6]) begin
                    chk("k_head", HEAD_OUT, e_mon.head);
                    chk("k_data", K_OUT, e_mon.data);
                end else if (e_mon.flags[5]) begin
                    chk("beta_head", HEAD_OUT, e_mon.head);
                    chk("beta_data", BETA_OUT, e_mon.data);
                end else if (e_mon.flags[4]) begin
                    chk("f_head", HEAD_OUT, e_mon.head);
                    chk("f_data", F_OUT, e_mon.data);
                end else if (e_mon.flags[2]) begin
                    chk("pi_head", HEAD_OUT, e_mon.head);
                    chk("pi_data", PI_OUT, e_mon.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        RST = 1'b0;
        chk("rst_ready", {63'd0, READY}, 64'd0);
        chk("rst_head", HEAD_OUT, 64'd0);
        chk("rst_k", K_OUT, 64'd0);
        chk("rst_pi", PI_OUT, 64'd0);

        // Reset during KEY of head 0.
        tick();
        START = 1'b1;
        SIZE_R_IN = 64'd2;
        SIZE_W_IN = 64'd3;
        tick();
        START = 1'b0;
        IFACE_IN_ENABLE = 1'b1;
        IFACE_IN = 64'd1;
        push_word(0, 64'd1, 2, 3, cyc + 1);
        tick();
        IFACE_IN_ENABLE = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_k", K_OUT, 64'd0);
        chk("mid_rst_kk", {63'd0, K_OUT_K_ENABLE}, 64'd0);
        chk("mid_rst_ready", {63'd0, READY}, 64'd0);
        IFACE_IN_ENABLE = 1'b1;  // FSM must be idle: these words are ignored
        IFACE_IN = 64'd99;
        tick();
        tick();
        tick();
        IFACE_IN_ENABLE = 1'b0;
        drain();

        // Contiguous 16-word stream 1..16.
        stim_q.delete();
        for (int i = 1; i <= 16; i++) stim_q.push_back(64'(i));
        send_stream(2, 3, 1'b0, -1);
        drain();
        chk("hold_k", K_OUT, 64'd11);
        chk("hold_beta", BETA_OUT, ONE);
        chk("hold_f", F_OUT, 64'd13);
        chk("hold_pi", PI_OUT, 64'd16);
        chk("hold_head", HEAD_OUT, 64'd1);

        // Same stream with idle gaps.
        send_stream(2, 3, 1'b1, -1);
        drain();

        // Clamp boundaries with W'=1.
        stim_q.delete();
        stim_q.push_back(64'd7);
        stim_q.push_back(64'h0000_0003_0000_0000);
        stim_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        stim_q.push_back(64'd20);
        stim_q.push_back(64'd21);
        stim_q.push_back(64'd22);
        stim_q.push_back(64'd8);
        stim_q.push_back(64'h8000_0000_0000_0000);
        stim_q.push_back(64'h0000_0002_0000_0000);
        stim_q.push_back(64'd23);
        stim_q.push_back(64'd24);
        stim_q.push_back(64'd25);
        send_stream(2, 1, 1'b0, -1);
        drain();

        // Rejected sizes.
        bad_start(0, 3);
        bad_start(3, 3);
        bad_start(2, 4);
        bad_start(1, 0);

        // Second START during head 1 is ignored.
        stim_q.delete();
        for (int i = 1; i <= 16; i++) stim_q.push_back(64'(i * 3));
        send_stream(2, 3, 1'b1, 10);
        drain();

        // A START right after completion parses a single head normally.
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(64'(100 + i));
        send_stream(1, 3, 1'b0, -1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/accelerator_read_heads_parser.md
Name: accelerator_read_heads_parser

Overview:
- Sequential demultiplexer for the DNC read-head section of the controller interface vector.
- Consumes one serial stream of fixed-point words and steers them into per-head read keys, read strengths, free gates and read modes.
- Supports a runtime count of up to R heads and W-word keys, and applies range conditioning to strengths and gates.
- Sits between the controller output and the free_gates / read_keys / read_modes / read_strengths consumers, driving their *_IN streams.

Parameters:
- DATA_SIZE, 64, word width (signed fixed point).
- CONTROL_SIZE, 64, width of the size/index counters.
- FRACT_SIZE, 32, fractional bits; ONE = 1 << FRACT_SIZE.
- R, 4, maximum number of read heads.
- W, 64, maximum key length in words.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  begin parsing; sampled in IDLE only.
- READY  out  1  one-cycle pulse when parsing completes or is rejected.
- ERROR  out  1  one-cycle pulse with READY when sizes are rejected.
- SIZE_R_IN  in  CONTROL_SIZE  heads in use, valid range 1..R.
- SIZE_W_IN  in  CONTROL_SIZE  key length, valid range 1..W.
- IFACE_IN_ENABLE  in  1  IFACE_IN valid this cycle.
- IFACE_IN  in  DATA_SIZE  interface word.
- HEAD_OUT  out  CONTROL_SIZE  head index of the current output word.
- K_OUT_I_ENABLE  out  1  first key word of a head.
- K_OUT_K_ENABLE  out  1  key word valid.
- K_OUT  out  DATA_SIZE  key word.
- BETA_OUT_ENABLE  out  1  strength valid.
- BETA_OUT  out  DATA_SIZE  strength, clamped to ≥ ONE.
- F_OUT_ENABLE  out  1  free gate valid.
- F_OUT  out  DATA_SIZE  free gate, clamped to [0, ONE].
- PI_OUT_I_ENABLE  out  1  first mode word of a head.
- PI_OUT_P_ENABLE  out  1  mode word valid.
- PI_OUT  out  DATA_SIZE  mode word, passed through unmodified.

Behaviour:
- Reset: state IDLE; all outputs, counters and latched sizes are 0. A reset mid-stream aborts the parse with no READY pulse.
- Per-head stream order: W' key words, then 1 beta, then 1 f, then 3 pi words, where W' = latched SIZE_W_IN. Heads follow in order 0..R'-1. Total words = R'·(W'+5).
- FSM states: IDLE, KEY, STRENGTH, GATE, MODE.
  - IDLE + START with sizes valid: latch SIZE_R_IN and SIZE_W_IN, clear head/word counters, go to KEY.
  - IDLE + START with sizes invalid (0, or > R, or > W): READY=ERROR=1 on the next cycle; stay IDLE.
  - KEY → STRENGTH after word W'-1.
  - STRENGTH → GATE after 1 word.
  - GATE → MODE after 1 word.
  - MODE → KEY after pi word 2 if head < R'-1, with head incremented.
  - MODE → IDLE after pi word 2 of the last head; READY pulses in the same cycle the last PI_OUT is presented.
- A state advances only on a cycle with IFACE_IN_ENABLE=1. Idle gaps of any length are legal.
- Latency: each output is registered, valid exactly 1 cycle after the accepted input word. Each enable is a one-cycle pulse. Data outputs hold their last value between enables.
- K_OUT_I_ENABLE and PI_OUT_I_ENABLE coincide with K_OUT_K_ENABLE / PI_OUT_P_ENABLE on the first word of their group.
- Clamping is a signed compare:
  - BETA_OUT = max(IFACE_IN, ONE).
  - F_OUT = min(max(IFACE_IN, 0), ONE).
- START while not in IDLE is ignored.
- IFACE_IN_ENABLE while in IDLE is ignored.
- Counters compare against latched sizes only; mid-parse changes to SIZE_* have no effect.
- Word counter wraps to 0 at each group boundary. No overflow is possible within the valid size range.

Decomposition:
- Shared package accelerator_dnc_pkg:
  - state enum (IDLE, KEY, STRENGTH, GATE, MODE);
  - ONE, ZERO and PI_WORDS = 3 constants;
  - a function returning total word count.
- One sub-module, accelerator_fixed_clamp (parameters DATA_SIZE, LO, HI, with HAS_HI to disable the upper bound), instanced once for beta and once for f.

Test Plan (bench config R=2, W=3, FRACT_SIZE=32, ONE=0x1_0000_0000):
- Reset during KEY of head 0 → all outputs 0 next cycle, no READY, FSM back in IDLE; a following START parses normally.
- START with SIZE_R_IN=2, SIZE_W_IN=3, 16 contiguous words 1..16 → K_OUT 1,2,3 with HEAD_OUT=0 and I_ENABLE on word 1; BETA_OUT=ONE (input 4 < ONE); F_OUT=5 (inside [0, ONE]); PI 6,7,8; head 1 repeats from word 9; READY coincides with PI_OUT=16.
- Beta input 0x3_0000_0000 → unchanged. F input −1 → 0. F input 0x2_0000_0000 → ONE.
- Same 16-word stream with IFACE_IN_ENABLE toggled 1,0,1,0 → identical output sequence, each output 1 cycle after its accepted word, with no outputs during gaps.
- START with SIZE_R_IN=0, then with SIZE_R_IN=3, then with SIZE_W_IN=4 → each produces READY=ERROR=1 one cycle later, no data enables, FSM remains IDLE.
- Second START issued during head 1 → ignored; exactly one READY at the end of the stream.
